// File: rtl/imp_ln_pkg.sv
// ---------------------------------------------------------------------------
// imp_ln_pkg
// Shared definitions for the improved LayerNorm datapath: the mean unit state
// encoding and helpers that derive the accumulator widths from the sample
// width and the vector length.
// ---------------------------------------------------------------------------
package imp_ln_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DIV  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Signed sum of n samples of data_w bits never needs more than this.
    function automatic int acc_w_f(input int data_w, input int n);
        return data_w + $clog2(n);
    endfunction

    // Unsigned sum of n squares of data_w-bit two's complement samples.
    function automatic int sq_w_f(input int data_w, input int n);
        return 2 * data_w - 1 + $clog2(n);
    endfunction

endpackage

// File: rtl/imp_seq_divu.sv
// ---------------------------------------------------------------------------
// imp_seq_divu
// Unsigned restoring divider, one quotient bit per clock, fixed iteration
// count equal to DVD_W. Pulsing start loads the operands; done pulses for one
// cycle when the quotient is final. The remainder is dropped.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   start         : load dividend/divisor and begin
//   dividend      : DVD_W-bit unsigned dividend
//   divisor       : DVS_W-bit unsigned non-zero divisor
//   busy          : iterations in progress
//   done          : one-cycle pulse, quotient valid
//   quotient      : low QUO_W bits of the quotient
// ---------------------------------------------------------------------------
module imp_seq_divu #(
    parameter int DVD_W = 12,
    parameter int DVS_W = 4,
    parameter int QUO_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    localparam int IC_W = $clog2(DVD_W + 1);
    localparam logic [IC_W-1:0] IC_LOAD = IC_W'(DVD_W);
    localparam logic [IC_W-1:0] IC_ONE  = IC_W'(1);

    logic [DVD_W-1:0] quo_r;
    logic [DVS_W-1:0] rem_r;
    logic [DVS_W-1:0] dvs_r;
    logic [IC_W-1:0]  itr_r;
    logic             busy_r;
    logic             done_r;

    logic [DVS_W:0]   rem_sh_s;
    logic [DVS_W-1:0] rem_nxt_s;
    logic [DVD_W-1:0] quo_nxt_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The remainder stays below the divisor, so the low DVS_W bits of the
    // difference are exact.
    always_comb begin
        rem_sh_s = {rem_r, quo_r[DVD_W-1]};
        if (rem_sh_s >= {1'b0, dvs_r}) begin
            rem_nxt_s = rem_sh_s[DVS_W-1:0] - dvs_r;
            quo_nxt_s = {quo_r[DVD_W-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s[DVS_W-1:0];
            quo_nxt_s = {quo_r[DVD_W-2:0], 1'b0};
        end
    end

    // Operand load, iteration and completion pulse.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            quo_r  <= '0;
            rem_r  <= '0;
            dvs_r  <= '0;
            itr_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                quo_r  <= dividend;
                rem_r  <= '0;
                dvs_r  <= divisor;
                itr_r  <= IC_LOAD;
                busy_r <= 1'b1;
            end else if (busy_r) begin
                quo_r <= quo_nxt_s;
                rem_r <= rem_nxt_s;
                itr_r <= itr_r - IC_ONE;
                if (itr_r == IC_ONE) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quo_r[QUO_W-1:0];

endmodule

// File: rtl/imp_mean_unit.sv
// ---------------------------------------------------------------------------
// imp_mean_unit
// Streaming mean of N signed samples. Samples arrive over a valid/ready
// channel, are summed, and the sum magnitude is divided by N in a sequential
// restoring divider; the sign is reapplied so the mean truncates toward zero.
// The result is held on a valid/ready output until consumed.
// Optional build macro IMP_MEAN_EX2_EN adds the mean of squares on o_ex2,
// computed by a second divider running in lockstep (longer latency).
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_valid/o_ready/i_x : sample input channel
//   o_valid/i_ready     : result output channel
//   o_ex   : signed mean, truncated toward zero
//   o_ex2  : unsigned floor mean of squares (IMP_MEAN_EX2_EN only)
//   o_busy : high whenever not idle
// ---------------------------------------------------------------------------
module imp_mean_unit
    import imp_ln_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int N      = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [DATA_W-1:0] i_x,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [DATA_W-1:0] o_ex,
`ifdef IMP_MEAN_EX2_EN
    output logic [2*DATA_W-2:0]      o_ex2,
`endif
    output logic                     o_busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int ACC_W = acc_w_f(DATA_W, N);
`ifdef IMP_MEAN_EX2_EN
    localparam int SQ_W  = sq_w_f(DATA_W, N);
    localparam int ITER  = SQ_W;
`else
    localparam int ITER  = ACC_W;
`endif
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] DIVISOR  = CNT_W'(N);

    state_e                    state_r;
    state_e                    state_nxt_s;
    logic signed [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]          cnt_r;
    logic signed [DATA_W-1:0]  ex_r;

    logic                      ready_s;
    logic                      accept_s;
    logic                      last_s;
    logic                      div_fin_s;
    logic signed [ACC_W-1:0]   sx_s;
    logic signed [ACC_W-1:0]   acc_nxt_s;
    logic [ACC_W-1:0]          acc_abs_s;
    logic                      div_busy_s;
    logic                      div_done_s;
    logic [DATA_W-1:0]         div_quo_s;

`ifdef IMP_MEAN_EX2_EN
    logic [SQ_W-1:0]           sq_r;
    logic [2*DATA_W-2:0]       ex2_r;
    logic signed [2*DATA_W-1:0] sq_prod_s;
    logic [SQ_W-1:0]           sq_add_s;
    logic [SQ_W-1:0]           sq_nxt_s;
    logic                      sq_busy_s;
    logic                      sq_done_s;
    logic [2*DATA_W-2:0]       sq_quo_s;
`endif

    // Input handshake, running sum and the magnitude handed to the divider.
    // The divider is started on the accept of the Nth sample, using the sum
    // that includes it, so no extra load cycle is spent.
    always_comb begin
        sx_s = {{(ACC_W - DATA_W){i_x[DATA_W-1]}}, i_x};
        case (state_r)
            ST_IDLE: ready_s = 1'b1;
            ST_ACC:  ready_s = 1'b1;
            default: ready_s = 1'b0;
        endcase
        accept_s = i_valid && ready_s;
        if (state_r == ST_IDLE) begin
            acc_nxt_s = sx_s;
        end else begin
            acc_nxt_s = acc_r + sx_s;
        end
        last_s = accept_s && (state_r == ST_ACC) && (cnt_r == LAST_CNT);
        if (acc_nxt_s[ACC_W-1]) begin
            acc_abs_s = -acc_nxt_s;
        end else begin
            acc_abs_s = acc_nxt_s;
        end
    end

`ifdef IMP_MEAN_EX2_EN
    // Square of the incoming sample and the next sum of squares.
    always_comb begin
        sq_prod_s = i_x * i_x;
        sq_add_s  = SQ_W'($unsigned(sq_prod_s));
        if (state_r == ST_IDLE) begin
            sq_nxt_s = sq_add_s;
        end else begin
            sq_nxt_s = sq_r + sq_add_s;
        end
    end

    // Both dividers share length and start, so they finish together.
    always_comb begin
        div_fin_s = div_done_s && !div_busy_s && sq_done_s && !sq_busy_s;
    end
`else
    // Divider completion.
    always_comb begin
        div_fin_s = div_done_s && !div_busy_s;
    end
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_ACC;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ACC: begin
                if (last_s) state_nxt_s = ST_DIV;
                else        state_nxt_s = ST_ACC;
            end
            ST_DIV: begin
                if (div_fin_s) state_nxt_s = ST_OUT;
                else           state_nxt_s = ST_DIV;
            end
            ST_OUT: begin
                if (i_ready) state_nxt_s = ST_IDLE;
                else         state_nxt_s = ST_OUT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Accumulator, sample count and result registers. The quotient magnitude
    // is at most 2^(DATA_W-1), so its low DATA_W bits negate correctly even
    // for the most negative mean.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_r <= '0;
            cnt_r <= '0;
            ex_r  <= '0;
        end else begin
            if (accept_s) begin
                acc_r <= acc_nxt_s;
                if (state_r == ST_IDLE) cnt_r <= CNT_ONE;
                else                    cnt_r <= cnt_r + CNT_ONE;
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
            if ((state_r == ST_DIV) && div_fin_s) begin
                if (acc_r[ACC_W-1]) ex_r <= -div_quo_s;
                else                ex_r <= div_quo_s;
            end else begin
                ex_r <= ex_r;
            end
        end
    end

    imp_seq_divu #(
        .DVD_W (ITER),
        .DVS_W (CNT_W),
        .QUO_W (DATA_W)
    ) u_div_ex (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .start    (last_s),
        .dividend (ITER'(acc_abs_s)),
        .divisor  (DIVISOR),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quo_s)
    );

`ifdef IMP_MEAN_EX2_EN
    // Sum of squares, loaded on the first sample, and its mean.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sq_r  <= '0;
            ex2_r <= '0;
        end else begin
            if (accept_s) sq_r <= sq_nxt_s;
            else          sq_r <= sq_r;
            if ((state_r == ST_DIV) && div_fin_s) ex2_r <= sq_quo_s;
            else                                  ex2_r <= ex2_r;
        end
    end

    imp_seq_divu #(
        .DVD_W (SQ_W),
        .DVS_W (CNT_W),
        .QUO_W (2 * DATA_W - 1)
    ) u_div_ex2 (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .start    (last_s),
        .dividend (sq_nxt_s),
        .divisor  (DIVISOR),
        .busy     (sq_busy_s),
        .done     (sq_done_s),
        .quotient (sq_quo_s)
    );

    assign o_ex2 = ex2_r;
`endif

    assign o_ready = ready_s;
    assign o_valid = (state_r == ST_OUT);
    assign o_busy  = (state_r != ST_IDLE);
    assign o_ex    = ex_r;

endmodule

// File: tb/tb_imp_mean_unit.sv
// ---------------------------------------------------------------------------
// tb_imp_mean_unit
// Directed bench for imp_mean_unit: one instance with N=8 and one with N=5
// share the stimulus; sel5 routes the handshake to one of them. Vectors are
// table driven, plus hand-written output-hold and reset-abort sequences.
// ---------------------------------------------------------------------------
module tb_imp_mean_unit;

`ifdef IMP_MEAN_EX2_EN
    localparam int LAT = 21;
`else
    localparam int LAT = 13;
`endif

    typedef struct {
        logic        sel5;
        logic [71:0] xs;
        logic        gaps;
        logic [8:0]  ex;
        logic [16:0] ex2;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel5;
    logic       i_valid;
    logic [8:0] i_x;
    logic       i_ready;

    logic        rdy8, ov8, busy8, rdy5, ov5, busy5;
    logic [8:0]  ex8, ex5;
    logic [16:0] ex2_8, ex2_5;

    int n_checks = 0;
    int n_fail   = 0;

    wire v8 = i_valid & ~sel5;
    wire v5 = i_valid & sel5;
    wire r8 = sel5 ? 1'b1 : i_ready;
    wire r5 = sel5 ? i_ready : 1'b1;

    wire        m_ready = sel5 ? rdy5 : rdy8;
    wire        m_valid = sel5 ? ov5 : ov8;
    wire        m_busy  = sel5 ? busy5 : busy8;
    wire [8:0]  m_ex    = sel5 ? ex5 : ex8;
    wire [16:0] m_ex2   = sel5 ? ex2_5 : ex2_8;

    always #5 clk = ~clk;

    imp_mean_unit #(.DATA_W(9), .N(8)) dut8 (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_valid (v8),
        .o_ready (rdy8),
        .i_x     (i_x),
        .o_valid (ov8),
        .i_ready (r8),
        .o_ex    (ex8),
`ifdef IMP_MEAN_EX2_EN
        .o_ex2   (ex2_8),
`endif
        .o_busy  (busy8)
    );

    imp_mean_unit #(.DATA_W(9), .N(5)) dut5 (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_valid (v5),
        .o_ready (rdy5),
        .i_x     (i_x),
        .o_valid (ov5),
        .i_ready (r5),
        .o_ex    (ex5),
`ifdef IMP_MEAN_EX2_EN
        .o_ex2   (ex2_5),
`endif
        .o_busy  (busy5)
    );

`ifndef IMP_MEAN_EX2_EN
    assign ex2_8 = 17'd0;
    assign ex2_5 = 17'd0;
`endif

    function automatic logic [71:0] pk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7);
        return {9'(a7), 9'(a6), 9'(a5), 9'(a4), 9'(a3), 9'(a2), 9'(a1), 9'(a0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Offer one sample until it is accepted on a rising edge.
    task automatic send(input logic [8:0] x);
        int g = 0;
        @(negedge clk);
        i_valid = 1'b1;
        i_x     = x;
        while (!m_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got o_ready=0 for 50 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic run_vec(input string nm, input logic s5, input logic [71:0] xs,
                           input logic gaps, input logic [8:0] ex, input logic [16:0] ex2,
                           input int hold);
        int   n;
        int   lat;
        logic rdy_bad;
        logic busy_bad;
        logic hold_bad;
        n        = s5 ? 5 : 8;
        sel5     = s5;
        i_ready  = (hold == 0);
        rdy_bad  = 1'b0;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    i_valid = 1'b0;
                end
            end
            send(xs[k*9 +: 9]);
        end
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (m_ready) rdy_bad = 1'b1;
            if (!m_busy) busy_bad = 1'b1;
        end while (!m_valid && lat < 100);
        chk({nm, " latency"}, 32'(lat), 32'(LAT));
        chk({nm, " ready_low"}, {31'd0, rdy_bad}, 32'd0);
        chk({nm, " busy_high"}, {31'd0, busy_bad}, 32'd0);
        chk({nm, " ex"}, {23'd0, m_ex}, {23'd0, ex});
`ifdef IMP_MEAN_EX2_EN
        chk({nm, " ex2"}, {15'd0, m_ex2}, {15'd0, ex2});
`endif
        if (hold > 0) begin
            i_valid = 1'b1;
            i_x     = 9'd99;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (!m_valid || m_ready || (m_ex !== ex)) hold_bad = 1'b1;
            end
            chk({nm, " hold_stable"}, {31'd0, hold_bad}, 32'd0);
            i_valid = 1'b0;
            i_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({nm, " valid_drop"}, {31'd0, m_valid}, 32'd0);
        chk({nm, " ex_retained"}, {23'd0, m_ex}, {23'd0, ex});
    endtask

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, pk(1, 2, 3, 4, 5, 6, 7, 8),                 1'b0, 9'd4,      17'd25};
        tbl[1] = '{1'b0, pk(-1, -2, -3, -4, -5, -6, -7, -8),         1'b1, 9'(-4),    17'd25};
        tbl[2] = '{1'b0, pk(-256, -256, -256, -256, -256, -256, -256, -256), 1'b0, 9'(-256), 17'd65536};
        tbl[3] = '{1'b0, pk(255, 255, 255, 255, 255, 255, 255, 255), 1'b0, 9'd255,    17'd65025};
        tbl[4] = '{1'b0, pk(100, -50, 7, 3, -1, 0, 20, -80),         1'b1, 9'd0,      17'd2419};
        tbl[5] = '{1'b0, pk(-5, -5, -5, -5, -5, -5, -5, -4),         1'b0, 9'(-4),    17'd23};
        tbl[6] = '{1'b1, pk(10, 20, 30, 40, -7, 0, 0, 0),            1'b0, 9'd18,     17'd609};
        tbl[7] = '{1'b1, pk(-3, -3, -3, -3, -3, 0, 0, 0),            1'b1, 9'(-3),    17'd9};
        tbl[8] = '{1'b1, pk(-256, -256, -256, -256, -256, 0, 0, 0),  1'b0, 9'(-256), 17'd65536};

        rst_n   = 1'b0;
        sel5    = 1'b0;
        i_valid = 1'b0;
        i_x     = 9'd0;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, m_valid}, 32'd0);
        chk("reset ex", {23'd0, m_ex}, 32'd0);
        chk("reset busy", {31'd0, m_busy}, 32'd0);
        chk("reset ready", {31'd0, m_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].sel5, tbl[i].xs, tbl[i].gaps,
                    tbl[i].ex, tbl[i].ex2, 0);
        end

        // N=5 result held for 6 cycles with a sample offered, then a clean vector.
        run_vec("hold5", 1'b1, pk(10, 20, 30, 40, -7, 0, 0, 0), 1'b0, 9'd18, 17'd609, 6);
        run_vec("after_hold5", 1'b1, pk(-3, -3, -3, -3, -3, 0, 0, 0), 1'b0, 9'(-3), 17'd9, 0);

        // Abort a partial N=8 vector with reset, then a full vector.
        sel5    = 1'b0;
        i_ready = 1'b1;
        run_vec("pre_abort", 1'b0, pk(-5, -5, -5, -5, -5, -5, -5, -4), 1'b0, 9'(-4), 17'd23, 0);
        send(9'd50);
        send(9'd60);
        send(9'd70);
        send(9'd80);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort valid", {31'd0, m_valid}, 32'd0);
        chk("abort ex", {23'd0, m_ex}, 32'd0);
        chk("abort busy", {31'd0, m_busy}, 32'd0);
        chk("abort ready", {31'd0, m_ready}, 32'd1);
`ifdef IMP_MEAN_EX2_EN
        chk("abort ex2", {15'd0, m_ex2}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_abort", 1'b0, pk(1, 2, 3, 4, 5, 6, 7, 8), 1'b0, 9'd4, 17'd25, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
